// File: rtl/uart_tx_tick_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_tick_pkg
// Description : Shared UART state encoding and frame-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_tick_pkg;

    localparam int c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_t;

    // Bit periods from the start-bit falling edge to the end of the last stop bit.
    function automatic int uart_frame_bits(input int data_bits,
                                           input int parity_en,
                                           input int stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_tick
// Description : UART transmitter paced by an external one-cycle bit-rate TICK.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_tick
    import uart_tx_tick_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 TICK,
    input  logic                 VALID,
    input  logic [DATA_BITS-1:0] DATA,
    output logic                 READY,
    output logic                 TX,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int                 c_CNT_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT   = c_CNT_W'(DATA_BITS - 1);
    localparam logic               c_LAST_STOP  = (STOP_BITS > 1);
    localparam logic               c_PARITY_INV = (PARITY_ODD != 0);

    uart_state_t          r_state,    w_state_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic                 r_parity,   w_parity_nxt;
    logic [c_CNT_W-1:0]   r_bit_cnt,  w_bit_cnt_nxt;
    logic                 r_stop_cnt, w_stop_cnt_nxt;
    logic                 r_tx,       w_tx_nxt;
    logic                 r_done,     w_done_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_parity_nxt   = r_parity;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_tx_nxt       = r_tx;
        w_done_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (VALID) begin
                    w_shift_nxt  = DATA;
                    w_parity_nxt = (^DATA) ^ c_PARITY_INV;
                    w_state_nxt  = ST_ALIGN;
                end
            end
            // Waiting for a tick here keeps the start bit a full bit period long.
            ST_ALIGN: begin
                if (TICK) begin
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (TICK) begin
                    w_tx_nxt      = r_shift[0];
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (TICK) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_stop_cnt_nxt = 1'b0;
                        if (PARITY_EN != 0) begin
                            w_tx_nxt    = r_parity;
                            w_state_nxt = ST_PARITY;
                        end else begin
                            w_tx_nxt    = 1'b1;
                            w_state_nxt = ST_STOP;
                        end
                    end else begin
                        w_shift_nxt   = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_tx_nxt      = r_shift[1];
                        w_bit_cnt_nxt = r_bit_cnt + c_CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (TICK) begin
                    w_tx_nxt       = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (TICK) begin
                    if (r_stop_cnt == c_LAST_STOP) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign READY = (r_state == ST_IDLE);
    assign BUSY  = (r_state != ST_IDLE);
    assign TX    = r_tx;
    assign DONE  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_tick.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_tick
// Description : Directed self-checking bench for uart_tx_tick (8N1 and 8E2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_tick;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       valid_a, valid_b;
    logic [7:0] data;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       ready_b, tx_b, busy_b, done_b;

    int n_checks = 0;
    int n_pass   = 0;
    int tick_div = 0;
    int tick_cnt = 0;

    logic tr_tx    [0:511];
    logic tr_done  [0:511];
    logic tr_busy  [0:511];
    logic tr_ready [0:511];
    int   tr_len, fall_idx, done_idx0, done_idx1;

    always #5 clk = ~clk;

    uart_tx_tick #(
        .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) u_dut_a (
        .CLK(clk), .RST(rst), .TICK(tick), .VALID(valid_a), .DATA(data),
        .READY(ready_a), .TX(tx_a), .BUSY(busy_a), .DONE(done_a)
    );

    uart_tx_tick #(
        .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
    ) u_dut_b (
        .CLK(clk), .RST(rst), .TICK(tick), .VALID(valid_b), .DATA(data),
        .READY(ready_b), .TX(tx_b), .BUSY(busy_b), .DONE(done_b)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock step; TICK pulses once every tick_div cycles (0 = never).
    task automatic cyc();
        @(posedge clk);
        #1;
        if (tick_div == 0) begin
            tick = 1'b0;
        end else if (tick_cnt >= tick_div - 1) begin
            tick_cnt = 0;
            tick     = 1'b1;
        end else begin
            tick_cnt++;
            tick = 1'b0;
        end
    endtask

    // Records one DUT's outputs per cycle until n_done DONE pulses plus two cycles.
    // VALID of the selected DUT is raised with pv_data on trace indices [pv_from, pv_to).
    task automatic capture(input bit sel, input int budget, input int n_done,
                           input int pv_from, input int pv_to, input logic [7:0] pv_data);
        int seen;
        int stop_at;
        seen      = 0;
        stop_at   = -1;
        fall_idx  = -1;
        done_idx0 = -1;
        done_idx1 = -1;
        tr_len    = 0;
        for (int i = 0; i < budget && i < 512; i++) begin
            cyc();
            tr_tx[i]    = sel ? tx_b    : tx_a;
            tr_done[i]  = sel ? done_b  : done_a;
            tr_busy[i]  = sel ? busy_b  : busy_a;
            tr_ready[i] = sel ? ready_b : ready_a;
            tr_len      = i + 1;
            if (fall_idx < 0 && tr_tx[i] === 1'b0) fall_idx = i;
            if (tr_done[i] === 1'b1) begin
                if (seen == 0) done_idx0 = i;
                else if (seen == 1) done_idx1 = i;
                seen++;
                if (seen == n_done) stop_at = i + 2;
            end
            if (i >= pv_from && i < pv_to) begin
                data = pv_data;
                if (sel) valid_b = 1'b1;
                else     valid_a = 1'b1;
            end else begin
                valid_a = 1'b0;
                valid_b = 1'b0;
            end
            if (stop_at >= 0 && i >= stop_at) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_a = 1'b1; valid_b = 1'b1; data = 8'h5A; tick_div = 0;
        repeat (3) cyc();
        n_checks++; if (tx_a !== 1'b1)    $display("FAIL reset_tx_a: got %b expected 1", tx_a);       else n_pass++;
        n_checks++; if (ready_a !== 1'b1) $display("FAIL reset_ready_a: got %b expected 1", ready_a); else n_pass++;
        n_checks++; if (busy_a !== 1'b0)  $display("FAIL reset_busy_a: got %b expected 0", busy_a);   else n_pass++;
        n_checks++; if (done_a !== 1'b0)  $display("FAIL reset_done_a: got %b expected 0", done_a);   else n_pass++;
        n_checks++; if (tx_b !== 1'b1)    $display("FAIL reset_tx_b: got %b expected 1", tx_b);       else n_pass++;
        n_checks++; if (busy_b !== 1'b0)  $display("FAIL reset_busy_b: got %b expected 0", busy_b);   else n_pass++;
        rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        cyc();
        n_checks++; if (busy_a !== 1'b0)  $display("FAIL reset_no_accept: got busy %b expected 0", busy_a); else n_pass++;
    endtask

    task automatic test_8n1();
        logic [9:0] e;
        bit         bad;
        e = {1'b1, 8'h55, 1'b0};
        tick_div = 6; data = 8'h55; valid_a = 1'b1;
        cyc();
        valid_a = 1'b0;
        n_checks++; if (ready_a !== 1'b0) $display("FAIL 8n1_ready_after_accept: got %b expected 0", ready_a); else n_pass++;
        capture(1'b0, 200, 1, 0, 0, 8'h00);
        n_checks++;
        if (fall_idx < 0 || done_idx0 < 0) begin
            $display("FAIL 8n1_frame_timeout: got fall %0d done %0d expected both >= 0", fall_idx, done_idx0);
        end else begin
            n_pass++;
            n_checks++;
            if (done_idx0 - fall_idx != 60) $display("FAIL 8n1_frame_len: got %0d expected 60", done_idx0 - fall_idx);
            else n_pass++;
            for (int k = 0; k < 10; k++) begin
                n_checks++;
                if (tr_tx[fall_idx + 6*k] !== e[k])
                    $display("FAIL 8n1_bit%0d_first: got %b expected %b", k, tr_tx[fall_idx + 6*k], e[k]);
                else n_pass++;
                n_checks++;
                if (tr_tx[fall_idx + 6*k + 5] !== e[k])
                    $display("FAIL 8n1_bit%0d_last: got %b expected %b", k, tr_tx[fall_idx + 6*k + 5], e[k]);
                else n_pass++;
            end
            bad = 1'b0;
            for (int i = 0; i < done_idx0; i++) if (tr_busy[i] !== 1'b1) bad = 1'b1;
            n_checks++; if (bad) $display("FAIL 8n1_busy_held: got a low BUSY expected 1 throughout"); else n_pass++;
            n_checks++;
            if (tr_done[done_idx0 + 1] !== 1'b0) $display("FAIL 8n1_done_width: got %b expected 0", tr_done[done_idx0 + 1]);
            else n_pass++;
            n_checks++;
            if (tr_ready[done_idx0] !== 1'b1) $display("FAIL 8n1_ready_at_done: got %b expected 1", tr_ready[done_idx0]);
            else n_pass++;
        end
    endtask

    task automatic test_8e2();
        logic [11:0] e;
        e = {2'b11, 1'b0, 8'hA3, 1'b0};
        tick_div = 4; data = 8'hA3; valid_b = 1'b1;
        cyc();
        valid_b = 1'b0;
        capture(1'b1, 200, 1, 0, 0, 8'h00);
        n_checks++;
        if (fall_idx < 0 || done_idx0 < 0) begin
            $display("FAIL 8e2_frame_timeout: got fall %0d done %0d expected both >= 0", fall_idx, done_idx0);
        end else begin
            n_pass++;
            n_checks++;
            if (done_idx0 - fall_idx != 48) $display("FAIL 8e2_frame_len: got %0d expected 48", done_idx0 - fall_idx);
            else n_pass++;
            for (int k = 0; k < 12; k++) begin
                n_checks++;
                if (tr_tx[fall_idx + 4*k] !== e[k])
                    $display("FAIL 8e2_bit%0d_first: got %b expected %b", k, tr_tx[fall_idx + 4*k], e[k]);
                else n_pass++;
                n_checks++;
                if (tr_tx[fall_idx + 4*k + 3] !== e[k])
                    $display("FAIL 8e2_bit%0d_last: got %b expected %b", k, tr_tx[fall_idx + 4*k + 3], e[k]);
                else n_pass++;
            end
        end
    endtask

    // With TICK constant, the accept cycle and ALIGN put DONE pulses 12 cycles apart.
    task automatic test_back_to_back();
        logic [22:0] e;
        e = 23'b1111111111_0_111_000000000;
        tick_div = 1; data = 8'h00; valid_a = 1'b1;
        cyc();
        valid_a = 1'b0;
        capture(1'b0, 100, 2, 0, 22, 8'hFF);
        n_checks++; if (done_idx0 != 10) $display("FAIL b2b_done1_idx: got %0d expected 10", done_idx0); else n_pass++;
        n_checks++; if (done_idx1 != 22) $display("FAIL b2b_done2_idx: got %0d expected 22", done_idx1); else n_pass++;
        if (tr_len >= 23) begin
            for (int i = 0; i < 23; i++) begin
                n_checks++;
                if (tr_tx[i] !== e[i]) $display("FAIL b2b_tx_idx%0d: got %b expected %b", i, tr_tx[i], e[i]);
                else n_pass++;
            end
        end else begin
            n_checks++;
            $display("FAIL b2b_trace_len: got %0d expected >= 23", tr_len);
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [9:0] e;
        bit         found;
        bit         any_done;
        e = {1'b1, 8'h81, 1'b0};
        tick_div = 3; data = 8'h0F; valid_a = 1'b1;
        cyc();
        valid_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (tx_a === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (!found) $display("FAIL rst_start_timeout: got no start bit expected one within 20 cycles"); else n_pass++;
        repeat (16) cyc();
        n_checks++; if (tx_a !== 1'b0) $display("FAIL rst_data_bit4: got %b expected 0", tx_a); else n_pass++;
        rst = 1'b1;
        cyc();
        n_checks++; if (tx_a !== 1'b1)    $display("FAIL rst_mid_tx: got %b expected 1", tx_a);       else n_pass++;
        n_checks++; if (done_a !== 1'b0)  $display("FAIL rst_mid_done: got %b expected 0", done_a);   else n_pass++;
        n_checks++; if (ready_a !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", ready_a); else n_pass++;
        rst = 1'b0;
        any_done = 1'b0;
        repeat (30) begin
            cyc();
            if (done_a !== 1'b0 || tx_a !== 1'b1) any_done = 1'b1;
        end
        n_checks++; if (any_done) $display("FAIL rst_idle_after: got DONE or low TX expected quiet line"); else n_pass++;
        data = 8'h81; valid_a = 1'b1;
        cyc();
        valid_a = 1'b0;
        capture(1'b0, 100, 1, 0, 0, 8'h00);
        n_checks++;
        if (fall_idx < 0 || done_idx0 < 0) begin
            $display("FAIL rst_next_timeout: got fall %0d done %0d expected both >= 0", fall_idx, done_idx0);
        end else begin
            n_pass++;
            n_checks++;
            if (done_idx0 - fall_idx != 30) $display("FAIL rst_next_len: got %0d expected 30", done_idx0 - fall_idx);
            else n_pass++;
            for (int k = 0; k < 10; k++) begin
                n_checks++;
                if (tr_tx[fall_idx + 3*k + 1] !== e[k])
                    $display("FAIL rst_next_bit%0d: got %b expected %b", k, tr_tx[fall_idx + 3*k + 1], e[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_valid_ignored();
        logic [9:0] e;
        bit         bad;
        e = {1'b1, 8'h3C, 1'b0};
        tick_div = 2; data = 8'h3C; valid_a = 1'b1;
        cyc();
        valid_a = 1'b0;
        capture(1'b0, 100, 1, 2, 14, 8'hC3);
        n_checks++;
        if (fall_idx < 0 || done_idx0 < 0) begin
            $display("FAIL busy_valid_timeout: got fall %0d done %0d expected both >= 0", fall_idx, done_idx0);
        end else begin
            n_pass++;
            n_checks++;
            if (done_idx0 - fall_idx != 20) $display("FAIL busy_valid_len: got %0d expected 20", done_idx0 - fall_idx);
            else n_pass++;
            for (int k = 0; k < 10; k++) begin
                n_checks++;
                if (tr_tx[fall_idx + 2*k + 1] !== e[k])
                    $display("FAIL busy_valid_bit%0d: got %b expected %b", k, tr_tx[fall_idx + 2*k + 1], e[k]);
                else n_pass++;
            end
            bad = 1'b0;
            for (int i = 0; i < done_idx0; i++) if (tr_ready[i] !== 1'b0) bad = 1'b1;
            n_checks++; if (bad) $display("FAIL busy_valid_ready: got a high READY expected 0 until DONE"); else n_pass++;
            n_checks++;
            if (tr_busy[done_idx0 + 2] !== 1'b0) $display("FAIL busy_valid_no_refire: got busy %b expected 0", tr_busy[done_idx0 + 2]);
            else n_pass++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        tick    = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data    = 8'h00;
        test_reset();
        test_8n1();
        test_8e2();
        test_back_to_back();
        test_mid_frame_reset();
        test_valid_ignored();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
